// File: rtl/game_state_ctrl.sv
// Round-level game sequencer: idle, ready, play, dying, over.
// Owns lives, score and the freeze/sprite-reset controls.
module game_state_ctrl #(
    parameter int unsigned LIVES         = 3,
    parameter int unsigned READY_FRAMES  = 120,
    parameter int unsigned DEATH_FRAMES  = 90,
    parameter int unsigned PELLET_POINTS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start_btn,
    input  logic        pacman_is_dead,
    input  logic        pellet_eaten,
    output logic        sprite_rst,
    output logic        freeze,
    output logic        game_over,
    output logic [2:0]  lives_left,
    output logic [15:0] score,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_PLAY  = 3'd2,
        S_DYING = 3'd3,
        S_OVER  = 3'd4
    } state_e;

    localparam logic [6:0]  READY_LAST = 7'(READY_FRAMES - 1);
    localparam logic [6:0]  DEATH_LAST = 7'(DEATH_FRAMES - 1);
    localparam logic [2:0]  LIVES_INIT = 3'(LIVES);
    localparam logic [16:0] PTS        = 17'(PELLET_POINTS);

    state_e      state_q, state_d;
    logic [6:0]  frm_q, frm_d;
    logic [2:0]  lives_q, lives_d;
    logic [15:0] score_q, score_d;
    logic        start_q;
    logic        sprite_q, sprite_d;
    logic        freeze_q, freeze_d;
    logic        over_q, over_d;

    logic        start_edge;
    logic        expire;
    logic [6:0]  frm_last;
    logic [16:0] sum;

    assign start_edge = start_btn & ~start_q;
    assign frm_last   = (state_q == S_DYING) ? DEATH_LAST : READY_LAST;
    assign expire     = frame_tick & (frm_q == frm_last);
    assign sum        = {1'b0, score_q} + PTS;

    // Next state, counters and the registered output controls.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        score_d = score_q;
        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start_edge) begin
                    lives_d = LIVES_INIT;
                    score_d = '0;
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (expire) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (pellet_eaten)
                    score_d = sum[16] ? 16'hFFFF : sum[15:0];
                if (pacman_is_dead) state_d = S_DYING;
            end
            S_DYING: begin
                if (expire) begin
                    lives_d = lives_q - 3'd1;
                    state_d = (lives_q == 3'd1) ? S_OVER : S_READY;
                end
            end
            default: state_d = S_IDLE;
        endcase

        frm_d = frm_q;
        if (state_d != state_q)
            frm_d = '0;
        else if (frame_tick &&
                 (state_q == S_READY || state_q == S_DYING))
            frm_d = frm_q + 7'd1;

        sprite_d = (state_d == S_IDLE) || (state_d == S_READY);
        freeze_d = (state_d != S_PLAY);
        over_d   = (state_d == S_OVER);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            frm_q    <= '0;
            lives_q  <= LIVES_INIT;
            score_q  <= '0;
            start_q  <= 1'b1;
            sprite_q <= 1'b1;
            freeze_q <= 1'b1;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            frm_q    <= frm_d;
            lives_q  <= lives_d;
            score_q  <= score_d;
            start_q  <= start_btn;
            sprite_q <= sprite_d;
            freeze_q <= freeze_d;
            over_q   <= over_d;
        end
    end

    assign sprite_rst = sprite_q;
    assign freeze     = freeze_q;
    assign game_over  = over_q;
    assign lives_left = lives_q;
    assign score      = score_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Randomised bench for game_state_ctrl, two parameter sets,
// compared every cycle against a phase-level reference model.
module tb_game_state_ctrl;

    localparam int RF = 4;
    localparam int DF = 3;
    localparam int P_IDLE  = 0;
    localparam int P_READY = 1;
    localparam int P_PLAY  = 2;
    localparam int P_DYING = 3;
    localparam int P_OVER  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic frame_tick = 1'b0;
    logic start_btn = 1'b0;
    logic pacman_is_dead = 1'b0;
    logic pellet_eaten = 1'b0;

    logic        sr_a, fz_a, go_a, sr_b, fz_b, go_b;
    logic [2:0]  lv_a, st_a, lv_b, st_b;
    logic [15:0] sc_a, sc_b;

    int vectors = 0;
    int miscompares = 0;

    int lv_init [2] = '{2, 3};
    int pts     [2] = '{10, 'h1FFF};
    int ph [2];
    int ticks [2];
    int lives [2];
    int scr [2];
    bit prev_btn;
    bit sat_seen = 0;

    always #5 clk = ~clk;

    game_state_ctrl #(
        .LIVES(2), .READY_FRAMES(RF),
        .DEATH_FRAMES(DF), .PELLET_POINTS(10)
    ) dut_a (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .start_btn(start_btn),
        .pacman_is_dead(pacman_is_dead),
        .pellet_eaten(pellet_eaten),
        .sprite_rst(sr_a), .freeze(fz_a),
        .game_over(go_a), .lives_left(lv_a),
        .score(sc_a), .state_out(st_a)
    );

    game_state_ctrl #(
        .LIVES(3), .READY_FRAMES(RF),
        .DEATH_FRAMES(DF), .PELLET_POINTS('h1FFF)
    ) dut_b (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .start_btn(start_btn),
        .pacman_is_dead(pacman_is_dead),
        .pellet_eaten(pellet_eaten),
        .sprite_rst(sr_b), .freeze(fz_b),
        .game_over(go_b), .lives_left(lv_b),
        .score(sc_b), .state_out(st_b)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ph[i] = P_IDLE;
            ticks[i] = 0;
            lives[i] = lv_init[i];
            scr[i] = 0;
        end
        prev_btn = 1'b1;
    endtask

    task automatic model_step(input int i, input bit sedge);
        case (ph[i])
            P_IDLE, P_OVER: if (sedge) begin
                lives[i] = lv_init[i];
                scr[i] = 0;
                ticks[i] = 0;
                ph[i] = P_READY;
            end
            P_READY: if (frame_tick) begin
                ticks[i]++;
                if (ticks[i] == RF) ph[i] = P_PLAY;
            end
            P_PLAY: begin
                if (pellet_eaten) begin
                    scr[i] = scr[i] + pts[i];
                    if (scr[i] > 65535) scr[i] = 65535;
                end
                if (pacman_is_dead) begin
                    ph[i] = P_DYING;
                    ticks[i] = 0;
                end
            end
            P_DYING: if (frame_tick) begin
                ticks[i]++;
                if (ticks[i] == DF) begin
                    lives[i]--;
                    ph[i] = (lives[i] == 0) ? P_OVER : P_READY;
                    ticks[i] = 0;
                end
            end
            default: ph[i] = P_IDLE;
        endcase
    endtask

    task automatic check_inst(input int i, input string n,
                              input logic [2:0] st,
                              input logic sr, input logic fz,
                              input logic go,
                              input logic [2:0] lv,
                              input logic [15:0] sc);
        bit esr, efz, ego;
        esr = (ph[i] == P_IDLE) || (ph[i] == P_READY);
        efz = (ph[i] != P_PLAY);
        ego = (ph[i] == P_OVER);
        chk({n, ".state"}, 32'(st), 32'(ph[i]));
        chk({n, ".sprite_rst"}, 32'(sr), 32'(esr));
        chk({n, ".freeze"}, 32'(fz), 32'(efz));
        chk({n, ".game_over"}, 32'(go), 32'(ego));
        chk({n, ".lives"}, 32'(lv), 32'(lives[i]));
        chk({n, ".score"}, 32'(sc), 32'(scr[i]));
    endtask

    task automatic check_all();
        check_inst(0, "A", st_a, sr_a, fz_a, go_a, lv_a, sc_a);
        check_inst(1, "B", st_b, sr_b, fz_b, go_b, lv_b, sc_b);
    endtask

    // Apply the inputs currently driven for one clock, then check.
    task automatic step();
        bit sedge;
        if (!rst) begin
            model_reset();
        end else begin
            sedge = start_btn & ~prev_btn;
            model_step(0, sedge);
            model_step(1, sedge);
            prev_btn = start_btn;
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
        if (sc_b == 16'hFFFF) sat_seen = 1;
    endtask

    initial begin
        bit found;
        model_reset();
        start_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all();

        rst = 1'b1;
        repeat (3) step();
        chk("A.idle_held", 32'(st_a), 32'(P_IDLE));
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        chk("A.start_ready", 32'(st_a), 32'(P_READY));
        chk("B.start_lives", 32'(lv_b), 32'd3);

        for (int c = 0; c < 4000; c++) begin
            frame_tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
            pacman_is_dead = ($urandom_range(0, 29) == 0);
            pellet_eaten = $urandom_range(0, 1) == 1;
            step();
        end
        chk("B.saturation_reached", 32'(sat_seen), 32'd1);

        found = 0;
        for (int c = 0; c < 500 && !found; c++) begin
            frame_tick = ($urandom_range(0, 1) == 0);
            start_btn = ~start_btn;
            pacman_is_dead = 1'b1;
            pellet_eaten = 1'b0;
            step();
            if (ph[0] == P_DYING) found = 1;
        end
        chk("A.reach_dying", 32'(found), 32'd1);

        pacman_is_dead = 1'b0;
        rst = 1'b0;
        #1;
        chk("A.async_state", 32'(st_a), 32'd0);
        chk("A.async_sprite", 32'(sr_a), 32'd1);
        chk("A.async_freeze", 32'(fz_a), 32'd1);
        chk("A.async_over", 32'(go_a), 32'd0);
        chk("A.async_lives", 32'(lv_a), 32'd2);
        chk("A.async_score", 32'(sc_a), 32'd0);
        chk("B.async_score", 32'(sc_b), 32'd0);
        model_reset();
        @(negedge clk);
        step();
        rst = 1'b1;
        start_btn = 1'b0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Round-level controller downstream of the game-logic top. It consumes the collision flag `pacman_is_dead` and per-frame ticks, and sequences the game through idle, ready, play, dying and game-over phases. It drives the sprite-reset and freeze controls back into the game logic, and keeps the lives and score counters that are shown on the display.

## Interface
- `LIVES`, 3: lives loaded at game start; legal range 1..7.
- `READY_FRAMES`, 120: frame ticks spent frozen at the spawn positions before play starts; must be ≥1.
- `DEATH_FRAMES`, 90: frame ticks spent frozen after a death; must be ≥1.
- `PELLET_POINTS`, 10: score added per pellet.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse, once per video frame.
- `start_btn` in 1: start button, already synchronised; only its rising edge acts.
- `pacman_is_dead` in 1: collision flag from the game logic; level, combinational at the source.
- `pellet_eaten` in 1: one-cycle pulse per pellet consumed.
- `sprite_rst` out 1: active-high; holds every sprite at its reset position.
- `freeze` out 1: active-high; the game logic must not update positions while it is set.
- `game_over` out 1: high in OVER.
- `lives_left` out 3: remaining lives.
- `score` out 16: accumulated score.
- `state_out` out 3: current state encoding.

## Operation
- State encodings:
  - IDLE = 0
  - READY = 1
  - PLAY = 2
  - DYING = 3
  - OVER = 4
  - Codes 5–7 are illegal and return to IDLE on the next edge.
- Start edge: `start_edge` = `start_btn` & ~`start_q`. `start_q` is a register that resets to 1, so a button held through reset does not start a game.
- Frame counter: `frm_cnt` is 7 bits. It clears on every state entry and increments on `frame_tick` only in READY and DYING.
- `expire` = `frame_tick` & (`frm_cnt` == N−1), where N is the frame count of the current state.
- IDLE:
  - `sprite_rst`=1, `freeze`=1.
  - On `start_edge`: lives ← `LIVES`, score ← 0, go to READY.
- READY:
  - `sprite_rst`=1, `freeze`=1.
  - On `expire` (N = `READY_FRAMES`): go to PLAY.
- PLAY:
  - `sprite_rst`=0, `freeze`=0.
  - If `pacman_is_dead`=1 at a clock edge: go to DYING.
  - Each `pellet_eaten` pulse adds `PELLET_POINTS` to score; score saturates at 16'hFFFF.
- DYING:
  - `sprite_rst`=0, `freeze`=1, so the sprites stay visible at the collision point.
  - On `expire` (N = `DEATH_FRAMES`): lives ← lives−1.
  - If the old value of lives was 1, go to OVER; otherwise go to READY.
- OVER:
  - `sprite_rst`=0, `freeze`=1, `game_over`=1.
  - On `start_edge`: lives ← `LIVES`, score ← 0, go to READY (not via IDLE).
- Events outside their states:
  - `pacman_is_dead` is ignored outside PLAY.
  - `pellet_eaten` is ignored outside PLAY.
  - `start_edge` is ignored in READY, PLAY and DYING.
- Score arithmetic: 17-bit sum of score and `PELLET_POINTS`. If bit 16 is set, score ← 16'hFFFF.

## Timing
- All outputs are registered and decoded from the registered state; there is no combinational path from inputs to outputs.
- Reset values: state IDLE, `sprite_rst`=1, `freeze`=1, `game_over`=0, `lives_left`=`LIVES`, `score`=0, `frm_cnt`=0, `start_q`=1.
- Reset asserted mid-game returns the block to the reset values immediately (asynchronous), whatever the current state.
- Latencies:
  - `pacman_is_dead` sampled high in PLAY at edge k: `freeze`=1 and `state_out`=3 after edge k.
  - `pellet_eaten` high at edge k: score is updated after edge k.
  - `start_edge` at edge k: state is READY after edge k.
- READY lasts exactly `READY_FRAMES` ticks, counting from the first tick after entry.
- A tick arriving in the same cycle as the state entry does not count, because the counter clears on entry.
- Same-cycle events at one edge, all in PLAY:
  - `pellet_eaten` and `pacman_is_dead` together: the pellet is scored and the state goes to DYING.
  - `frame_tick` together with the death: no effect, since the counter clears on entry to DYING.

## Test plan
- **Start from reset.** Release `rst`, hold `start_btn` high, then release and press again → state stays IDLE until the second rising edge; then READY, `lives_left`=3, `score`=0.
- **Ready hold.** Set `READY_FRAMES`=4, pulse `frame_tick` every 5 cycles → PLAY entered exactly 1 cycle after the 4th tick; `sprite_rst` falls at that same edge.
- **Scoring and saturation.** In PLAY, 3 `pellet_eaten` pulses → `score`=30. Preload the score to 16'hFFF8 and send 1 pulse → `score`=16'hFFFF; a further pulse leaves it unchanged.
- **Death to game over.** With `LIVES`=2, assert `pacman_is_dead` in PLAY twice (letting each DYING and READY phase run to completion in between) → after the first DYING, `lives_left`=1 and state READY; after the second, `lives_left`=0, state OVER, `game_over`=1.
- **Simultaneous events.** In PLAY, pulse `pellet_eaten` and raise `pacman_is_dead` in the same cycle → score +10 and state DYING on that edge. Assert `pacman_is_dead` during READY → ignored.
- **Restart and asynchronous reset.** In OVER, a `start_btn` edge → READY with `lives_left`=3 and `score`=0. Asserting `rst` low mid-DYING → outputs take their reset values without waiting for a `clk` edge.
